alu_core: RTL and testbench

- Registered arithmetic/logic unit that sits directly upstream of the flag register.
- Executes one operation per accepted request on two WIDTH-bit operands and registers the result.
- Drives the carry, borrow and zero flag inputs, plus the carry/borrow update strobe, consumed by the flag register.
- Single-cycle ops complete in 1 clock; MUL is a sequential shift-add taking WIDTH+1 clocks.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core_if.sv | 30 +++
 rtl/alu_mul_seq.sv | 59 +++++
 rtl/alu_core.sv | 122 ++++++++++++
 tb/tb_alu_core.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, width and state definitions for the ALU core and its multiplier.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
  localparam logic [OP_W-1:0] OP_AND  = 4'd2;
  localparam logic [OP_W-1:0] OP_OR   = 4'd3;
  localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
  localparam logic [OP_W-1:0] OP_NOT  = 4'd5;
  localparam logic [OP_W-1:0] OP_SHL  = 4'd6;
  localparam logic [OP_W-1:0] OP_SHR  = 4'd7;
  localparam logic [OP_W-1:0] OP_MUL  = 4'd8;
  localparam logic [OP_W-1:0] OP_PASS = 4'd9;

  typedef logic [0:0] alu_state_t;

  localparam alu_state_t S_IDLE    = 1'b0;
  localparam alu_state_t S_MUL_RUN = 1'b1;

endpackage

// File: rtl/alu_core_if.sv
// Request/result bundle between the ALU core and its requester / flag register.
interface alu_core_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             alu_start;
  logic [OP_W-1:0]  alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_busy;
  logic             alu_done;
  logic [WIDTH-1:0] alu_result;
  logic             alu_flag_c;
  logic             alu_flag_b;
  logic             alu_flag_z;
  logic             alu_flag_cb_valid;

  modport master (
    output alu_start, alu_op, alu_a, alu_b,
    input  alu_busy, alu_done, alu_result,
    input  alu_flag_c, alu_flag_b, alu_flag_z, alu_flag_cb_valid
  );

  modport slave (
    input  alu_start, alu_op, alu_a, alu_b,
    output alu_busy, alu_done, alu_result,
    output alu_flag_c, alu_flag_b, alu_flag_z, alu_flag_cb_valid
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: WIDTH iterations timed by a down-counter.
// finish_o marks the last iteration; product_o is the accumulator value it produces.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               finish_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] acc_next;

  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign finish_o  = (cnt_q == CNT_W'(1));
  assign product_o = acc_next;

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      cnt_d    = CNT_W'(WIDTH);
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      acc_d    = '0;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CNT_W'(1);
      mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
      acc_d    = acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Registered ALU feeding the flag register: single-cycle ops plus sequential MUL.
//   state     | meaning
//   S_IDLE    | accepting requests; single-cycle ops complete here
//   S_MUL_RUN | multiplier iterating; requests ignored
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     alu_rst_n,
  alu_core_if.slave bus
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             c_q, c_d;
  logic             b_q, b_d;
  logic             cbv_q, cbv_d;
  logic [WIDTH:0]   sum_ext;
  logic             accept;
  logic             mul_go;
  logic             mul_finish;
  logic [2*WIDTH-1:0] mul_product;

  assign accept  = bus.alu_start && (state_q == S_IDLE);
  assign mul_go  = accept && (bus.alu_op == OP_MUL);
  assign sum_ext = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (alu_rst_n),
    .start_i   (mul_go),
    .a_i       (bus.alu_a),
    .b_i       (bus.alu_b),
    .finish_o  (mul_finish),
    .product_o (mul_product)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    c_d      = c_q;
    b_d      = b_q;
    done_d   = 1'b0;
    cbv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.alu_op == OP_MUL) begin
            state_d = S_MUL_RUN;
          end else begin
            done_d = 1'b1;
            case (bus.alu_op)
              OP_ADD: begin
                result_d = sum_ext[WIDTH-1:0];
                c_d = sum_ext[WIDTH]; b_d = 1'b0; cbv_d = 1'b1;
              end
              OP_SUB: begin
                result_d = bus.alu_a - bus.alu_b;
                c_d = 1'b0; b_d = (bus.alu_a < bus.alu_b); cbv_d = 1'b1;
              end
              OP_AND:  result_d = bus.alu_a & bus.alu_b;
              OP_OR:   result_d = bus.alu_a | bus.alu_b;
              OP_XOR:  result_d = bus.alu_a ^ bus.alu_b;
              OP_NOT:  result_d = ~bus.alu_a;
              OP_SHL: begin
                result_d = {bus.alu_a[WIDTH-2:0], 1'b0};
                c_d = bus.alu_a[WIDTH-1]; b_d = 1'b0; cbv_d = 1'b1;
              end
              OP_SHR: begin
                result_d = {1'b0, bus.alu_a[WIDTH-1:1]};
                c_d = bus.alu_a[0]; b_d = 1'b0; cbv_d = 1'b1;
              end
              OP_PASS: result_d = bus.alu_b;
              default: ;  // undefined opcode: completes but leaves result and flags alone
            endcase
          end
        end
      end
      S_MUL_RUN: begin
        if (mul_finish) begin
          result_d = mul_product[WIDTH-1:0];
          c_d      = |mul_product[2*WIDTH-1:WIDTH];
          b_d      = 1'b0;
          cbv_d    = 1'b1;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      c_q      <= 1'b0;
      b_q      <= 1'b0;
      cbv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      c_q      <= c_d;
      b_q      <= b_d;
      cbv_q    <= cbv_d;
    end
  end

  assign bus.alu_busy          = (state_q == S_MUL_RUN);
  assign bus.alu_done          = done_q;
  assign bus.alu_result        = result_q;
  assign bus.alu_flag_c        = c_q;
  assign bus.alu_flag_b        = b_q;
  assign bus.alu_flag_z        = (result_q == '0);
  assign bus.alu_flag_cb_valid = cbv_q;

endmodule

// File: tb/tb_alu_core.sv
// Directed-vector bench for alu_core with hand-computed expectations.
module tb_alu_core;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  alu_core_if #(.WIDTH(8)) bus ();

  alu_core #(.WIDTH(8)) dut (
    .clk       (clk),
    .alu_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive a request for one edge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    bus.alu_start = 1'b1;
    bus.alu_op    = op;
    bus.alu_a     = a;
    bus.alu_b     = b;
    @(negedge clk);
    bus.alu_start = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] res, input logic c,
                         input logic b, input logic z, input logic cbv);
    chk({tag, ".done"}, 16'(bus.alu_done), 16'd1);
    chk({tag, ".res"},  16'(bus.alu_result), 16'(res));
    chk({tag, ".c"},    16'(bus.alu_flag_c), 16'(c));
    chk({tag, ".b"},    16'(bus.alu_flag_b), 16'(b));
    chk({tag, ".z"},    16'(bus.alu_flag_z), 16'(z));
    chk({tag, ".cbv"},  16'(bus.alu_flag_cb_valid), 16'(cbv));
  endtask

  initial begin
    int busy_cnt;
    int done_at;
    int done_seen;

    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.alu_start = 1'b0;
    bus.alu_op    = '0;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    repeat (2) @(negedge clk);
    chk("rst.res",  16'(bus.alu_result), 16'h0);
    chk("rst.z",    16'(bus.alu_flag_z), 16'd1);
    chk("rst.busy", 16'(bus.alu_busy), 16'd0);
    chk("rst.done", 16'(bus.alu_done), 16'd0);
    chk("rst.cbv",  16'(bus.alu_flag_cb_valid), 16'd0);
    rst_n = 1'b1;

    issue(OP_ADD, 8'hF0, 8'h20);
    chk_out("add", 8'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(OP_ADD, 8'hFF, 8'h01);
    chk_out("add_wrap", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);

    issue(OP_SUB, 8'h05, 8'h07);
    chk_out("sub_bor", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b1);
    issue(OP_SUB, 8'h33, 8'h33);
    chk_out("sub_eq", 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("done_pulse", 16'(bus.alu_done), 16'd0);

    // MUL with an ignored ADD during busy; AND issued in the done cycle.
    issue(OP_MUL, 8'h12, 8'h10);
    busy_cnt = 0;
    done_at  = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.alu_done) begin
        done_at = i;
        break;
      end
      if (bus.alu_busy) busy_cnt++;
      if (i == 2) begin
        bus.alu_start = 1'b1; bus.alu_op = OP_ADD; bus.alu_a = 8'h01; bus.alu_b = 8'h01;
      end else begin
        bus.alu_start = 1'b0;
      end
      if (i == 4) chk("mul_hold.res", 16'(bus.alu_result), 16'h00);
      @(negedge clk);
    end
    chk("mul.busy_cycles", 16'(busy_cnt), 16'd8);
    chk("mul.done_cycle", 16'(done_at), 16'd8);
    chk_out("mul", 8'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("mul.busy_end", 16'(bus.alu_busy), 16'd0);

    bus.alu_start = 1'b1; bus.alu_op = OP_AND; bus.alu_a = 8'hF0; bus.alu_b = 8'h3C;
    @(negedge clk);
    bus.alu_op = OP_XOR; bus.alu_a = 8'hFF; bus.alu_b = 8'hFF;
    chk_out("and", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bus.alu_start = 1'b0;
    chk_out("xor", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

    issue(OP_SHL, 8'h81, 8'h00);
    chk_out("shl", 8'h02, 1'b1, 1'b0, 1'b0, 1'b1);
    issue(OP_SHR, 8'h01, 8'h00);
    chk_out("shr", 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    issue(OP_NOT, 8'h0F, 8'h00);
    chk_out("not", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(OP_OR, 8'h50, 8'h0A);
    chk_out("or", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(4'hF, 8'h12, 8'h34);
    chk_out("undef", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(OP_PASS, 8'h00, 8'hA5);
    chk_out("pass", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset asserted on the 4th busy cycle of a MUL.
    issue(OP_MUL, 8'h03, 8'h04);
    repeat (3) @(negedge clk);
    chk("abort.busy_pre", 16'(bus.alu_busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("abort.res",  16'(bus.alu_result), 16'h00);
    chk("abort.z",    16'(bus.alu_flag_z), 16'd1);
    chk("abort.busy", 16'(bus.alu_busy), 16'd0);
    chk("abort.c",    16'(bus.alu_flag_c), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.alu_done) done_seen++;
    end
    chk("abort.no_done", 16'(done_seen), 16'd0);
    issue(OP_ADD, 8'h01, 8'h01);
    chk_out("post_rst_add", 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
